// File: rtl/act_requant_unit.sv
// Activation + requantization unit: N parallel lanes through a 2-stage valid/ready pipeline.
// S1 applies the activation and rounding offset; S2 shifts, saturates, clips and flags.
module act_requant_unit #(
  parameter int unsigned N     = 32,
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*IN_W-1:0]    z_in,
  input  logic [1:0]           mode,
  input  logic [OUT_W-1:0]     clip_max,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*OUT_W-1:0]   a_out,
  output logic                 sat_flag,
  output logic [15:0]          sat_count,
  input  logic                 sat_clr
);

  localparam int unsigned VW = IN_W + 1;
  localparam int unsigned EW = (VW > OUT_W + 1) ? VW : OUT_W + 1;

  localparam logic [1:0] M_RELU  = 2'b00;
  localparam logic [1:0] M_CLIP  = 2'b01;
  localparam logic [1:0] M_IDENT = 2'b10;
  localparam logic [1:0] M_LEAKY = 2'b11;

  localparam logic signed [VW-1:0] RND  = (ROUND != 0) ? VW'(1 << (SHIFT - 1)) : '0;
  localparam logic signed [EW-1:0] QMAX = EW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EW-1:0] QMIN = ~QMAX;

  // Activation plus rounding offset; one extra bit keeps the add from overflowing.
  function automatic logic signed [VW-1:0] activate(input logic signed [IN_W-1:0] z,
                                                    input logic [1:0]             m);
    logic signed [IN_W-1:0] v;
    v = z;
    if (z[IN_W-1]) begin
      if (m == M_LEAKY) begin
        v = z >>> 3;
      end else if (m != M_IDENT) begin
        v = '0;
      end
    end
    return VW'(v) + RND;
  endfunction

  // Returns {changed, result}: arithmetic shift, saturate, then optional clip ceiling.
  function automatic logic [OUT_W:0] requant(input logic signed [VW-1:0] v,
                                             input logic [1:0]           m,
                                             input logic [OUT_W-1:0]     clip);
    logic signed [EW-1:0] q;
    logic signed [EW-1:0] cl;
    logic                 chg;
    q   = EW'(v) >>> SHIFT;
    cl  = $signed(EW'({1'b0, clip}));
    chg = 1'b0;
    if (q > QMAX) begin
      q   = QMAX;
      chg = 1'b1;
    end else if (q < QMIN) begin
      q   = QMIN;
      chg = 1'b1;
    end
    if ((m == M_CLIP) && (q > cl)) begin
      q   = cl;
      chg = 1'b1;
    end
    return {chg, OUT_W'(q)};
  endfunction

  logic                   s1_valid_q;
  logic signed [VW-1:0]   s1_v_q [N];
  logic signed [VW-1:0]   s1_v_d [N];
  logic [1:0]             s1_mode_q;
  logic [OUT_W-1:0]       s1_clip_q;

  logic                   s2_valid_q;
  logic [N*OUT_W-1:0]     a_out_q;
  logic [N*OUT_W-1:0]     a_out_d;
  logic                   sat_flag_q;
  logic                   sat_flag_d;
  logic [15:0]            sat_count_q;

  logic                   s2_adv;
  logic                   s1_adv;
  logic [OUT_W:0]         lane_res;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = !rst && s1_adv;

  assign out_valid = s2_valid_q;
  assign a_out     = a_out_q;
  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_count_q;

  // S1 datapath
  always_comb begin
    for (int i = 0; i < N; i++) begin
      s1_v_d[i] = activate($signed(z_in[i*IN_W +: IN_W]), mode);
    end
  end

  // S2 datapath
  always_comb begin
    a_out_d    = '0;
    sat_flag_d = 1'b0;
    lane_res   = '0;
    for (int i = 0; i < N; i++) begin
      lane_res                   = requant(s1_v_q[i], s1_mode_q, s1_clip_q);
      a_out_d[i*OUT_W +: OUT_W]  = lane_res[OUT_W-1:0];
      sat_flag_d                 = sat_flag_d | lane_res[OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= M_RELU;
      s1_clip_q   <= '0;
      for (int i = 0; i < N; i++) begin
        s1_v_q[i] <= '0;
      end
      s2_valid_q  <= 1'b0;
      a_out_q     <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mode_q <= mode;
          s1_clip_q <= clip_max;
          for (int i = 0; i < N; i++) begin
            s1_v_q[i] <= s1_v_d[i];
          end
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          a_out_q    <= a_out_d;
          sat_flag_q <= sat_flag_d;
        end
      end
      // Clear takes priority over a coincident increment.
      if (sat_clr) begin
        sat_count_q <= '0;
      end else if (s2_valid_q && out_ready && sat_flag_q && (sat_count_q != 16'hFFFF)) begin
        sat_count_q <= sat_count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_act_requant_unit.sv
// Directed bench for act_requant_unit at default parameters; lanes beyond those driven are zero.
module tb_act_requant_unit;

  localparam int unsigned N     = 32;
  localparam int unsigned IN_W  = 20;
  localparam int unsigned OUT_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [N*IN_W-1:0]  z_in;
  logic [1:0]         mode;
  logic [OUT_W-1:0]   clip_max;
  logic               out_valid;
  logic               out_ready;
  logic [N*OUT_W-1:0] a_out;
  logic               sat_flag;
  logic [15:0]        sat_count;
  logic               sat_clr;

  int tests = 0;
  int fails = 0;
  int nxt;
  int expq [$];
  int exp_v;
  logic acc;
  logic dlv;

  act_requant_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z_in      (z_in),
    .mode      (mode),
    .clip_max  (clip_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .sat_flag  (sat_flag),
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane(input int i);
    return a_out[i*OUT_W +: OUT_W];
  endfunction

  task automatic set_z(input int l0, input int l1, input int l2, input int l3);
    z_in = '0;
    z_in[0*IN_W +: IN_W] = IN_W'(l0);
    z_in[1*IN_W +: IN_W] = IN_W'(l1);
    z_in[2*IN_W +: IN_W] = IN_W'(l2);
    z_in[3*IN_W +: IN_W] = IN_W'(l3);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    mode = 2'b00; clip_max = '0; z_in = '0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_a_out_l0", lane(0), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // ReLU, two-cycle latency, positive saturation
    set_z(-5, 384, 300, 32767); mode = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_not_yet", out_valid, 0);
    step();
    chk("relu_valid", out_valid, 1);
    chk("relu_l0", lane(0), 8'h00);
    chk("relu_l1", lane(1), 8'h02);
    chk("relu_l2", lane(2), 8'h01);
    chk("relu_l3", lane(3), 8'h7F);
    chk("relu_l4_zero", lane(4), 8'h00);
    chk("relu_flag", sat_flag, 1);
    chk("relu_cnt_before", sat_count, 0);
    step();
    chk("relu_drained", out_valid, 0);
    chk("relu_cnt_after", sat_count, 1);

    // Leaky beat followed immediately by identity beat
    set_z(-2048, -524288, 0, 0); mode = 2'b11; in_valid = 1'b1;
    step();
    set_z(-384, 0, 0, 0); mode = 2'b10;
    step();
    in_valid = 1'b0;
    chk("leaky_l0", lane(0), 8'hFF);
    chk("leaky_l1", lane(1), 8'h80);
    chk("leaky_flag", sat_flag, 1);
    step();
    chk("ident_valid", out_valid, 1);
    chk("ident_l0", lane(0), 8'hFF);
    chk("ident_flag", sat_flag, 0);
    chk("ident_cnt", sat_count, 2);
    step();
    chk("ident_cnt_after", sat_count, 2);

    // Clipped ReLU beat, then ReLU beat with same data
    set_z(2560, 1024, 0, 0); mode = 2'b01; clip_max = 8'd6; in_valid = 1'b1;
    step();
    set_z(2560, 0, 0, 0); mode = 2'b00; clip_max = 8'd0;
    step();
    in_valid = 1'b0;
    chk("clip_l0", lane(0), 8'h06);
    chk("clip_l1", lane(1), 8'h04);
    chk("clip_flag", sat_flag, 1);
    step();
    chk("after_clip_l0", lane(0), 8'h0A);
    chk("after_clip_flag", sat_flag, 0);
    step();
    chk("clip_cnt", sat_count, 3);

    // Backpressure: out_ready low for 5 cycles under continuous input
    nxt = 1;
    mode = 2'b10;
    for (int c = 0; c < 40 && (nxt <= 6 || expq.size() > 0); c++) begin
      if (c == 5) begin
        chk("held_beats", expq.size(), 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
      end
      out_ready = (c >= 5);
      in_valid  = (nxt <= 6);
      set_z(nxt * 256, 0, 0, 0);
      #1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (out_valid && !out_ready) begin
        chk("hold_l0", lane(0), expq[0]);
      end
      if (dlv) begin
        if (expq.size() > 0) exp_v = expq.pop_front();
        else exp_v = 32'hDEAD_BEEF;
        chk("order_l0", lane(0), exp_v);
      end
      if (acc) begin
        expq.push_back(nxt);
        nxt++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("bp_all_sent", nxt, 7);
    chk("bp_drained", expq.size(), 0);
    chk("bp_cnt", sat_count, 3);

    // Saturating counter: far more flagged beats than the counter can hold
    set_z(32767, 0, 0, 0); mode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    step(); step(); step();
    chk("cnt_saturated", sat_count, 16'hFFFF);

    // Clear coinciding with a flagged handshake
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_beat_valid", out_valid, 1);
    chk("clr_beat_flag", sat_flag, 1);
    chk("cnt_still_max", sat_count, 16'hFFFF);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    chk("cnt_cleared", sat_count, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("cnt_after_clr", sat_count, 1);

    // Reset with two beats in flight
    set_z(32767, 0, 0, 0); in_valid = 1'b1;
    step();
    set_z(512, 0, 0, 0);
    step();
    chk("inflight_valid", out_valid, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    step();
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_cnt", sat_count, 0);
    chk("rst_mid_flag", sat_flag, 0);
    chk("rst_mid_l0", lane(0), 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_after", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("no_stale", out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
